// File: rtl/hazard_pkg.sv
// Shared opcode/funct3 constants, FSM state encoding and decode helpers
// for the hazard and control-flow unit.
package hazard_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Stall counter holds up to LOAD_LAT-1 = 14.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_SHADOW = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } id_fields_t;

  function automatic id_fields_t decode_fields(input logic [31:0] instr);
    id_fields_t f;
    f.opcode = instr[6:0];
    f.funct3 = instr[14:12];
    f.rs1    = instr[19:15];
    f.rs2    = instr[24:20];
    return f;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational RV32I branch condition evaluator (BEQ..BGEU); reserved
// funct3 codes 010/011 resolve as not taken.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);
  import hazard_pkg::*;

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use stall sequencer and branch/jump redirect control beside ID.
// Optional saturating perf counters are enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic               ex_mem_read,
  input  logic [RADDR_W-1:0] ex_rd_addr,
  output logic               pc_mux_sel,
  output logic               pc_stop,
  output logic               if_flush,
  output logic               ctrl_mux_sel,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
);
  import hazard_pkg::*;

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  id_fields_t         fld;
  logic [RADDR_W-1:0] rs1_addr;
  logic [RADDR_W-1:0] rs2_addr;
  logic               br_taken;
  logic               hz;
  logic               tk;
  logic               unused_instr_bits;

  assign fld      = decode_fields(id_instr);
  assign rs1_addr = RADDR_W'(fld.rs1);
  assign rs2_addr = RADDR_W'(fld.rs2);
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[11:7]};

  branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .funct3 (fld.funct3),
    .rs1    (id_rs1_data),
    .rs2    (id_rs2_data),
    .taken  (br_taken)
  );

  assign hz = ex_mem_read && (ex_rd_addr != '0) &&
              ((uses_rs1(fld.opcode) && (ex_rd_addr == rs1_addr)) ||
               (uses_rs2(fld.opcode) && (ex_rd_addr == rs2_addr)));

  assign tk = (fld.opcode == OPC_JAL) || (fld.opcode == OPC_JALR) ||
              ((fld.opcode == OPC_BRANCH) && br_taken);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_mux_sel   = 1'b0;
    pc_stop      = 1'b0;
    if_flush     = 1'b0;
    ctrl_mux_sel = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id_valid) begin
          // A branch behind a pending load is held until its operands are final.
          if (hz) begin
            pc_stop      = 1'b1;
            ctrl_mux_sel = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = ST_STALL;
              cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
          end else if (tk) begin
            pc_mux_sel   = 1'b1;
            if_flush     = 1'b1;
            ctrl_mux_sel = 1'b1;
            state_d      = ST_SHADOW;
          end
        end
      end
      ST_STALL: begin
        pc_stop      = 1'b1;
        ctrl_mux_sel = 1'b1;
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      ST_SHADOW: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (rst) begin
      pc_mux_sel   = 1'b0;
      pc_stop      = 1'b0;
      if_flush     = 1'b0;
      ctrl_mux_sel = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stop && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + 32'd1;
    if (if_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // NOTE: counters are explicitly reset because software reads them directly after boot.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=1 and 3) share stimulus and are
// compared each cycle against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;

  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd_addr = '0;

  logic        sel_a, stop_a, flush_a, bub_a;
  logic        sel_b, stop_b, flush_b, bub_b;
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.XLEN(32), .RADDR_W(5), .LOAD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .pc_mux_sel(sel_a), .pc_stop(stop_a), .if_flush(flush_a), .ctrl_mux_sel(bub_a),
    .perf_stall_cnt(scnt_a), .perf_flush_cnt(fcnt_a)
  );

  hazard_ctrl_unit #(.XLEN(32), .RADDR_W(5), .LOAD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .pc_mux_sel(sel_b), .pc_stop(stop_b), .if_flush(flush_b), .ctrl_mux_sel(bub_b),
    .perf_stall_cnt(scnt_b), .perf_flush_cnt(fcnt_b)
  );

  int checks = 0;
  int failures = 0;

  logic [67:0] exp_q0[$];
  logic [67:0] exp_q1[$];

  // Model state: remaining stall cycles, pending shadow cycle, counters.
  int     m_stall[2] = '{0, 0};
  bit     m_shadow[2] = '{0, 0};
  longint m_scnt[2] = '{0, 0};
  longint m_fcnt[2] = '{0, 0};
  int     m_lat[2] = '{LAT_A, LAT_B};

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got sel/stop/flush/bub=%b%b%b%b scnt=%0d fcnt=%0d want %b%b%b%b scnt=%0d fcnt=%0d",
               name, $time, act[67], act[66], act[65], act[64], act[63:32], act[31:0],
               exp[67], exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
    end
  endtask

  function automatic bit ref_taken(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    logic [6:0] opc;
    opc = instr[6:0];
    if (opc == T_JAL || opc == T_JALR) return 1'b1;
    if (opc != T_BRANCH) return 1'b0;
    case (instr[14:12])
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_hazard(input logic [31:0] instr, input logic mr, input logic [4:0] rd);
    logic [6:0] opc;
    bit u1, u2;
    opc = instr[6:0];
    u1 = !(opc == T_LUI || opc == T_AUIPC || opc == T_JAL);
    u2 = (opc == T_BRANCH || opc == T_STORE || opc == T_OP);
    return mr && rd != 0 && ((u1 && rd == instr[19:15]) || (u2 && rd == instr[24:20]));
  endfunction

  task automatic model_cycle(input int k);
    bit sel, stop, flush, bub;
    logic [67:0] e;
    sel = 0; stop = 0; flush = 0; bub = 0;
    e[63:32] = 32'(m_scnt[k]);
    e[31:0]  = 32'(m_fcnt[k]);
`ifndef HAZARD_PERF_CNT_EN
    e[63:0] = '0;
`endif
    if (rst) begin
      m_stall[k] = 0; m_shadow[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
    end else begin
      if (m_shadow[k]) begin
        m_shadow[k] = 0;
      end else if (m_stall[k] > 0) begin
        stop = 1; bub = 1; m_stall[k]--;
      end else if (id_valid) begin
        if (ref_hazard(id_instr, ex_mem_read, ex_rd_addr)) begin
          stop = 1; bub = 1; m_stall[k] = m_lat[k] - 1;
        end else if (ref_taken(id_instr, id_rs1_data, id_rs2_data)) begin
          sel = 1; flush = 1; bub = 1; m_shadow[k] = 1;
        end
      end
      if (stop && m_scnt[k] < 64'hFFFF_FFFF) m_scnt[k]++;
      if (flush && m_fcnt[k] < 64'hFFFF_FFFF) m_fcnt[k]++;
    end
    e[67:64] = {sel, stop, flush, bub};
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] instr,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic mr, input logic [4:0] rd);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_instr = instr;
    id_rs1_data = a; id_rs2_data = b; ex_mem_read = mr; ex_rd_addr = rd;
    model_cycle(0);
    model_cycle(1);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    return {7'b0, r2, r1, f3, rd, opc};
  endfunction

  // Monitor: each negedge the DUTs present one response per instance.
  always @(negedge clk) begin
    if (exp_q0.size() > 0) check("lat1_out", {sel_a, stop_a, flush_a, bub_a, scnt_a, fcnt_a}, exp_q0.pop_front());
    if (exp_q1.size() > 0) check("lat3_out", {sel_b, stop_b, flush_b, bub_b, scnt_b, fcnt_b}, exp_q1.pop_front());
  end

  logic [6:0] opc_tab[10] = '{T_BRANCH, T_JAL, T_JALR, T_LOAD, T_STORE, T_OP, T_OP_IMM, T_LUI, T_AUIPC, 7'h7F};

  initial begin
    logic [31:0] add_i, beq_i, jal_i, ri, ra, rb;
    add_i = mk(T_OP, 3'b000, 5'd7, 5'd2, 5'd3);
    beq_i = mk(T_BRANCH, 3'b000, 5'd7, 5'd2, 5'd0);
    jal_i = mk(T_JAL, 3'b000, 5'd0, 5'd0, 5'd1);

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, jal_i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Signed vs unsigned compares.
    step(0, 1, mk(T_BRANCH, 3'b100, 5'd1, 5'd2, 5'd0), 32'hFFFF_FFFF, 32'd1, 0, 0);
    step(0, 1, mk(T_BRANCH, 3'b100, 5'd1, 5'd2, 5'd0), 32'hFFFF_FFFF, 32'd1, 0, 0);
    step(0, 1, mk(T_BRANCH, 3'b110, 5'd1, 5'd2, 5'd0), 32'hFFFF_FFFF, 32'd1, 0, 0);
    step(0, 1, mk(T_BRANCH, 3'b101, 5'd1, 5'd2, 5'd0), 32'd5, 32'd5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, mk(T_BRANCH, 3'b010, 5'd1, 5'd2, 5'd0), 32'd5, 32'd5, 0, 0);

    // Load-use on add x3,x7,x2, then the same with rd=x0.
    step(0, 1, add_i, 0, 0, 1, 5'd7);
    repeat (3) step(0, 1, add_i, 0, 0, 0, 5'd7);
    step(0, 1, add_i, 0, 0, 1, 5'd0);
    step(0, 0, 0, 0, 0, 0, 0);

    // BEQ behind a load: stall, then redirect, then shadow.
    step(0, 1, beq_i, 32'd9, 32'd9, 1, 5'd7);
    repeat (5) step(0, 1, beq_i, 32'd9, 32'd9, 0, 5'd0);

    // JAL repeated into the shadow slot.
    repeat (3) step(0, 1, jal_i, 0, 0, 0, 0);

    // Reset mid-stall, then fresh inputs.
    step(0, 1, add_i, 0, 0, 1, 5'd7);
    step(0, 1, add_i, 0, 0, 0, 5'd7);
    step(1, 1, add_i, 0, 0, 1, 5'd7);
    step(0, 1, jal_i, 0, 0, 0, 0);
    step(0, 1, add_i, 0, 0, 1, 5'd2);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      ri = mk(opc_tab[$urandom_range(0, 9)], 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      ri[31:25] = 7'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom_range(0, 4));
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), ri, ra, rb,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard and control-flow unit for the 5-stage core: successor to the single-cycle branch/jump flush logic. It resolves all six RV32I branch conditions with correct signed/unsigned compares and handles JAL/JALR. It detects load-use hazards between ID and EX and sequences multi-cycle stalls plus a post-redirect shadow cycle. It sits beside the ID stage and drives PC mux, PC hold, IF/ID flush and the ID/EX bubble mux.

## Interface
Parameters:
- XLEN, 32, register data width
- RADDR_W, 5, register address width
- LOAD_LAT, 1, stall cycles for load-use (legal 1..15)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  instruction in ID
- id_rs1_data  in  XLEN  forwarded rs1 value
- id_rs2_data  in  XLEN  forwarded rs2 value
- ex_mem_read  in  1  EX instruction is a load
- ex_rd_addr  in  RADDR_W  EX destination register
- pc_mux_sel  out  1  1 = select branch/jump target
- pc_stop  out  1  hold PC and IF/ID
- if_flush  out  1  clear IF/ID
- ctrl_mux_sel  out  1  1 = insert bubble into ID/EX
- perf_stall_cnt  out  32  load-use stall cycle count
- perf_flush_cnt  out  32  redirect count

## Operation
- FSM states: IDLE, STALL, SHADOW.
- The unit evaluates hazards and branches only in IDLE with id_valid=1.
- Load-use hazard (hz):
  - Condition: ex_mem_read & ex_rd_addr!=0 & ((rs1 used & rd==rs1) | (rs2 used & rd==rs2)).
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by BRANCH, STORE, OP.
- Branch taken (tk):
  - BEQ ==, BNE !=.
  - BLT <, BGE >= (signed).
  - BLTU <, BGEU >= (unsigned).
  - JAL and JALR are always taken.
  - funct3 010/011 under BRANCH: not taken.
- Priority: hz beats tk. A branch waiting on a load is not resolved until the stall ends.
- In IDLE, on hz: pc_stop=1, ctrl_mux_sel=1.
  - LOAD_LAT=1: stay in IDLE.
  - LOAD_LAT>1: go to STALL, cnt<=LOAD_LAT-1.
- In STALL: pc_stop=1, ctrl_mux_sel=1, cnt decrements. When cnt==1, return to IDLE. Total stall length is exactly LOAD_LAT cycles.
- In IDLE, on tk (no hz): pc_mux_sel=1, if_flush=1, ctrl_mux_sel=1, pc_stop=0. Next state is SHADOW.
- In SHADOW:
  - All outputs are 0 and id_instr is ignored.
  - Return to IDLE unconditionally.
  - This cycle guards against the flushed slot being re-evaluated.
- id_valid=0 in IDLE: all outputs 0, state holds.
- Outputs are combinational from state and inputs. Only state, cnt and the counters are registered.

## Timing
- Reset (rst=1 at posedge): state<=IDLE, cnt<=0, both perf counters <=0.
- While rst=1, all four control outputs are forced to 0.
- Decision latency: 0 cycles (same-cycle combinational) in IDLE.
- Redirect: one cycle of if_flush/pc_mux_sel, then exactly one SHADOW cycle.
- Back-to-back hazards: a new hz is sampled in the first IDLE cycle after STALL. The unit does not return to IDLE early.
- rst asserted mid-STALL or in SHADOW: the next cycle is IDLE with all outputs 0.
- Counter wrap: both counters saturate at 32'hFFFF_FFFF; they do not wrap.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - perf_stall_cnt increments on every cycle with pc_stop=1.
  - perf_flush_cnt increments on every cycle with if_flush=1.
  - Both saturate.
- Undefined: both ports are tied to 0, no counter flops are synthesised, and the port list is unchanged.

## Structure
- Shared package hazard_pkg holds:
  - Opcode constants: BRANCH 1100011, JAL 1101111, JALR 1100111, LOAD, STORE, OP, OP_IMM, LUI, AUIPC.
  - funct3 constants BEQ..BGEU.
  - FSM state encoding.
- One sub-module, branch_cmp (XLEN-parametrised, combinational). It takes funct3, rs1 and rs2 and returns taken.
- Counters and FSM stay in hazard_ctrl_unit.

## Test plan
- BLT, rs1=32'hFFFF_FFFF, rs2=1 -> taken. BLTU with the same operands -> not taken. BGE with rs1=5, rs2=5 -> taken.
- LOAD_LAT=1: ex_mem_read=1, ex_rd=7; ID holds `add x3,x7,x2` -> pc_stop=ctrl_mux_sel=1 for exactly 1 cycle. ex_rd=0 with the same instruction -> no stall.
- LOAD_LAT=3: load-use hazard with a BEQ in ID and equal operands -> 3 stall cycles, then the redirect pulse, then 1 SHADOW cycle with all outputs 0.
- JAL in ID, then JAL still present in the SHADOW cycle -> exactly one if_flush pulse. The second JAL is ignored.
- rst pulsed in the 2nd cycle of a LOAD_LAT=4 stall -> outputs 0 during rst; the next cycle is IDLE and resolves fresh inputs.
- HAZARD_PERF_CNT_EN defined, 3 hazards at LOAD_LAT=2 plus 2 taken branches -> perf_stall_cnt=6, perf_flush_cnt=2. Undefined -> both read 0.
